// File: rtl/bpu_update_scheduler.sv
// bpu_update_scheduler: sequences fetch GHR pushes and FIFO-buffered commit updates onto the BPU's single update port.
// Optional statistics outputs are enabled by defining BPU_UPD_STATS_EN.
`timescale 1ns/1ps
module bpu_update_scheduler #(
  parameter int XLEN           = 32,
  parameter int PREDITOR_DEPTH = 64,
  parameter int QDEPTH         = 4,
  parameter int STARVE_LIMIT   = 3,
  localparam int IDXW = $clog2(PREDITOR_DEPTH),
  localparam int PTRW = $clog2(QDEPTH),
  localparam int CNTW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_in,
  input  logic            spec_valid,
  output logic            spec_ready,
  input  logic            spec_taken,
  input  logic            cm_valid,
  output logic            cm_ready,
  input  logic            cm_taken,
  input  logic [IDXW-1:0] cm_index,
  input  logic            cm_btb_wr,
  input  logic            cm_type,
  input  logic [XLEN-1:0] cm_target,
  input  logic [XLEN-1:0] cm_addr,
  output logic            bpu_flush,
  output logic            bpu_ghr_upd,
  output logic            bpu_pred_upd,
  output logic            bpu_btb_upd,
  output logic            bpu_last_result,
  output logic [IDXW-1:0] bpu_last_index,
  output logic            bpu_branch_type,
  output logic [XLEN-1:0] bpu_target,
  output logic [XLEN-1:0] bpu_branch_addr,
  output logic [PTRW:0]   q_count
`ifdef BPU_UPD_STATS_EN
  ,
  output logic [31:0]     stat_pop_cnt,
  output logic [31:0]     stat_merge_cnt,
  output logic [31:0]     stat_block_cnt
`endif
);

  localparam logic [0:0]    S_NORMAL   = 1'b0;
  localparam logic [0:0]    S_BLOCK    = 1'b1;
  localparam logic [PTRW:0] L_QFULL    = (PTRW + 1)'(QDEPTH);
  localparam logic [CNTW-1:0] L_LIMIT_M1 = CNTW'(STARVE_LIMIT - 1);

  typedef struct packed {
    logic            taken;
    logic [IDXW-1:0] index;
    logic            btb_wr;
    logic            br_type;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] addr;
  } entry_t;

  entry_t          r_mem [QDEPTH];
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW:0]   r_q_count;
  logic [0:0]      r_state;
  logic [CNTW-1:0] r_starve;

  entry_t w_head;
  entry_t w_cm_entry;
  logic   w_h;
  logic   w_spec_acc;
  logic   w_pop;
  logic   w_push;

  assign spec_ready = (r_state == S_NORMAL);
  assign cm_ready   = (r_q_count != L_QFULL);
  assign q_count    = r_q_count;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_cm_entry = '{taken: cm_taken, index: cm_index, btb_wr: cm_btb_wr,
                        br_type: cm_type, target: cm_target, addr: cm_addr};
  assign w_h        = (r_q_count != '0);
  assign w_spec_acc = spec_valid && spec_ready && !flush_in;
  // Head leaves when no GHR push competes, or when both share the same lastResult value.
  assign w_pop      = w_h && (!w_spec_acc || (spec_taken == w_head.taken));
  assign w_push     = cm_valid && cm_ready;

  // NOTE: payload storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cm_entry;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_q_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
      case ({w_push, w_pop})
        2'b10:   r_q_count <= r_q_count + (PTRW + 1)'(1);
        2'b01:   r_q_count <= r_q_count - (PTRW + 1)'(1);
        default: r_q_count <= r_q_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_NORMAL;
      r_starve <= '0;
    end else if (r_state == S_BLOCK) begin
      r_state  <= S_NORMAL;
      r_starve <= '0;
    end else if (w_pop) begin
      r_starve <= '0;
    end else if (w_h) begin
      if (r_starve == L_LIMIT_M1) begin
        r_state  <= S_BLOCK;
        r_starve <= '0;
      end else begin
        r_starve <= r_starve + CNTW'(1);
      end
    end
  end

  // Every BPU strobe and its payload is a one-cycle registered pulse, zero when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bpu_flush       <= 1'b0;
      bpu_ghr_upd     <= 1'b0;
      bpu_pred_upd    <= 1'b0;
      bpu_btb_upd     <= 1'b0;
      bpu_last_result <= 1'b0;
      bpu_last_index  <= '0;
      bpu_branch_type <= 1'b0;
      bpu_target      <= '0;
      bpu_branch_addr <= '0;
    end else begin
      bpu_flush       <= flush_in;
      bpu_ghr_upd     <= w_spec_acc;
      bpu_pred_upd    <= w_pop;
      bpu_btb_upd     <= w_pop && w_head.btb_wr;
      bpu_last_result <= w_pop ? w_head.taken : (w_spec_acc && spec_taken);
      bpu_last_index  <= w_pop ? w_head.index   : '0;
      bpu_branch_type <= w_pop && w_head.br_type;
      bpu_target      <= w_pop ? w_head.target  : '0;
      bpu_branch_addr <= w_pop ? w_head.addr    : '0;
    end
  end

`ifdef BPU_UPD_STATS_EN
  logic w_merge;
  assign w_merge = w_spec_acc && w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_pop_cnt   <= '0;
      stat_merge_cnt <= '0;
      stat_block_cnt <= '0;
    end else begin
      if (w_pop)              stat_pop_cnt   <= stat_pop_cnt + 32'd1;
      if (w_merge)            stat_merge_cnt <= stat_merge_cnt + 32'd1;
      if (r_state == S_BLOCK) stat_block_cnt <= stat_block_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Self-checking bench for bpu_update_scheduler: queue-based reference model plus directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_bpu_update_scheduler;

  localparam int XLEN   = 32;
  localparam int IDXW   = 6;
  localparam int QDEPTH = 4;
  localparam int SLIMIT = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush_in = 1'b0;
  logic            spec_valid = 1'b0;
  logic            spec_ready;
  logic            spec_taken = 1'b0;
  logic            cm_valid = 1'b0;
  logic            cm_ready;
  logic            cm_taken = 1'b0;
  logic [IDXW-1:0] cm_index = '0;
  logic            cm_btb_wr = 1'b0;
  logic            cm_type = 1'b0;
  logic [XLEN-1:0] cm_target = '0;
  logic [XLEN-1:0] cm_addr = '0;
  logic            bpu_flush, bpu_ghr_upd, bpu_pred_upd, bpu_btb_upd, bpu_last_result;
  logic [IDXW-1:0] bpu_last_index;
  logic            bpu_branch_type;
  logic [XLEN-1:0] bpu_target, bpu_branch_addr;
  logic [2:0]      q_count;
`ifdef BPU_UPD_STATS_EN
  logic [31:0]     stat_pop_cnt, stat_merge_cnt, stat_block_cnt;
`endif

  bpu_update_scheduler dut (
    .clock(clock), .reset(reset), .flush_in(flush_in),
    .spec_valid(spec_valid), .spec_ready(spec_ready), .spec_taken(spec_taken),
    .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_taken(cm_taken), .cm_index(cm_index),
    .cm_btb_wr(cm_btb_wr), .cm_type(cm_type), .cm_target(cm_target), .cm_addr(cm_addr),
    .bpu_flush(bpu_flush), .bpu_ghr_upd(bpu_ghr_upd), .bpu_pred_upd(bpu_pred_upd),
    .bpu_btb_upd(bpu_btb_upd), .bpu_last_result(bpu_last_result),
    .bpu_last_index(bpu_last_index), .bpu_branch_type(bpu_branch_type),
    .bpu_target(bpu_target), .bpu_branch_addr(bpu_branch_addr), .q_count(q_count)
`ifdef BPU_UPD_STATS_EN
    , .stat_pop_cnt(stat_pop_cnt), .stat_merge_cnt(stat_merge_cnt), .stat_block_cnt(stat_block_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: commit entries in a queue, plus a wait count and a one-cycle block flag.
  typedef struct packed {
    bit        taken;
    bit [5:0]  idx;
    bit        btb;
    bit        typ;
    bit [31:0] tgt;
    bit [31:0] addr;
  } ent_t;

  ent_t        mq[$];
  int          m_wait = 0;
  bit          m_block = 1'b0;
  logic [75:0] exp_out = '0;
  logic [31:0] pop_log[$];

  function automatic logic [75:0] act_out();
    return {bpu_flush, bpu_ghr_upd, bpu_pred_upd, bpu_btb_upd, bpu_last_result,
            bpu_last_index, bpu_branch_type, bpu_target, bpu_branch_addr};
  endfunction

  function automatic void model_step();
    int   sz = mq.size();
    bit   h = (sz > 0);
    bit   sacc = spec_valid && !m_block && !flush_in;
    bit   pop = h && (!sacc || (spec_taken == mq[0].taken));
    ent_t hd;
    hd = '0;
    if (pop) hd = mq.pop_front();
    exp_out = {flush_in, sacc, pop, pop && hd.btb,
               pop ? hd.taken : (sacc && spec_taken),
               hd.idx, hd.typ, hd.tgt, hd.addr};
    if (cm_valid && sz != QDEPTH)
      mq.push_back('{cm_taken, cm_index, cm_btb_wr, cm_type, cm_target, cm_addr});
    if (m_block) begin
      m_block = 1'b0;
      m_wait  = 0;
    end else if (pop) begin
      m_wait = 0;
    end else if (h) begin
      m_wait++;
      if (m_wait == SLIMIT) begin
        m_block = 1'b1;
        m_wait  = 0;
      end
    end
  endfunction

  // Compare process: inputs are stable at the falling edge, so check then advance the model.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        mq.delete();
        m_wait  = 0;
        m_block = 1'b0;
        exp_out = '0;
        check("rst_out", act_out(), 76'd0);
        check("rst_q_count", q_count, 0);
      end else begin
        check("bpu_out", act_out(), exp_out);
        check("q_count", q_count, mq.size());
        check("cm_ready", cm_ready, mq.size() != QDEPTH);
        check("spec_ready", spec_ready, !m_block);
        if (bpu_pred_upd) pop_log.push_back(bpu_branch_addr);
        model_step();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    flush_in = 0; spec_valid = 0; spec_taken = 0; cm_valid = 0;
    repeat (n) cyc();
  endtask

  task automatic set_cm(input bit tk, input bit [5:0] ix, input bit bw, input bit ty,
                        input bit [31:0] tg, input bit [31:0] ad);
    cm_valid = 1; cm_taken = tk; cm_index = ix; cm_btb_wr = bw; cm_type = ty;
    cm_target = tg; cm_addr = ad;
  endtask

  initial begin
    bit acc;
    int tries;
    repeat (3) cyc();
    reset = 0;
    check("reset_q_count", q_count, 0);
    check("reset_cm_ready", cm_ready, 1);
    check("reset_spec_ready", spec_ready, 1);
    check("reset_outputs", act_out(), 76'd0);

    // Single commit: pulse appears two edges after presentation.
    set_cm(1, 5, 1, 0, 32'h100, 32'h40);
    cyc();
    cm_valid = 0;
    check("single_not_early", bpu_pred_upd, 0);
    check("single_q1", q_count, 1);
    cyc();
    check("single_pred", bpu_pred_upd, 1);
    check("single_btb", bpu_btb_upd, 1);
    check("single_index", bpu_last_index, 5);
    check("single_result", bpu_last_result, 1);
    check("single_target", bpu_target, 32'h100);
    check("single_addr", bpu_branch_addr, 32'h40);
    cyc();
    check("single_pulse", bpu_pred_upd, 0);
    idle(4);

    // Merge of a not-taken head with a not-taken GHR push.
    set_cm(0, 9, 0, 1, 32'h200, 32'h80);
    cyc();
    cm_valid = 0; spec_valid = 1; spec_taken = 0;
    check("merge_q1", q_count, 1);
    cyc();
    spec_valid = 0;
    check("merge_ghr", bpu_ghr_upd, 1);
    check("merge_pred", bpu_pred_upd, 1);
    check("merge_result", bpu_last_result, 0);
    check("merge_q0", q_count, 0);
    idle(4);

    // Starvation: three GHR pushes, then one blocked cycle that drains the head.
    set_cm(1, 3, 0, 0, 32'h0, 32'h50);
    cyc();
    cm_valid = 0; spec_valid = 1; spec_taken = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("starve_ghr", bpu_ghr_upd, 1);
      check("starve_no_pred", bpu_pred_upd, 0);
      check("starve_ready", spec_ready, (i < 2));
    end
    cyc();
    spec_valid = 0;
    check("block_no_ghr", bpu_ghr_upd, 0);
    check("block_pred", bpu_pred_upd, 1);
    check("block_result", bpu_last_result, 1);
    check("block_ready_back", spec_ready, 1);
    idle(4);

    // Full FIFO: five commits against mismatching spec traffic.
    pop_log.delete();
    spec_valid = 1; spec_taken = 0;
    for (int k = 0; k < 5; k++) begin
      set_cm(1, 6'(k), k[0], 0, 32'h2000 + k, 32'h1000 + k);
      tries = 0;
      do begin
        acc = cm_ready;
        cyc();
        tries++;
      end while (!acc && tries < 20);
      if (!acc) check("full_accept_timeout", 0, 1);
      if (k == 3) begin
        check("full_cm_ready", cm_ready, 0);
        check("full_q_count", q_count, 4);
      end
    end
    idle(8);
    check("full_pop_total", pop_log.size(), 5);
    for (int k = 0; k < 5 && k < pop_log.size(); k++)
      check("full_pop_order", pop_log[k], 32'h1000 + k);

    // Flush: GHR request dropped, commits keep draining in order.
    set_cm(1, 1, 0, 0, 32'h0, 32'h300);
    cyc();
    set_cm(0, 2, 0, 0, 32'h0, 32'h304);
    flush_in = 1; spec_valid = 1; spec_taken = 1;
    cyc();
    flush_in = 0; spec_valid = 0; cm_valid = 0;
    check("flush_out", bpu_flush, 1);
    check("flush_no_ghr", bpu_ghr_upd, 0);
    check("flush_pred_a", bpu_pred_upd, 1);
    check("flush_addr_a", bpu_branch_addr, 32'h300);
    cyc();
    check("flush_clear", bpu_flush, 0);
    check("flush_pred_b", bpu_pred_upd, 1);
    check("flush_addr_b", bpu_branch_addr, 32'h304);
    idle(4);

    // Reset while three entries wait behind mismatching spec pushes.
    spec_valid = 1; spec_taken = 0;
    for (int k = 0; k < 3; k++) begin
      set_cm(1, 6'(k), 1, 0, 32'h0, 32'h500 + k);
      cyc();
    end
    check("rstmid_q3", q_count, 3);
    cm_valid = 0; spec_valid = 0;
    reset = 1;
    #1;
    check("rstmid_out_now", act_out(), 76'd0);
    check("rstmid_q0", q_count, 0);
    cyc();
    cyc();
    reset = 0;
    pop_log.delete();
    idle(6);
    check("rstmid_no_pred", pop_log.size(), 0);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1;
        cyc();
        reset = 0;
      end
      flush_in   = ($urandom_range(0, 9) == 0);
      spec_valid = ($urandom_range(0, 3) != 0);
      spec_taken = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1)
        set_cm($urandom_range(0, 1), 6'($urandom_range(0, 63)), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom, $urandom);
      else
        cm_valid = 0;
      cyc();
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
